// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register of the MIPS datapath.
//
// Captures decoded control, register-file operands, the sign-extended
// immediate and register specifiers at the end of ID and presents them to EX
// for one cycle. Supports hazard-unit stall (hold everything) and flush
// (insert a bubble), and keeps a saturating count of inserted bubbles.
//
// Parameters:
//   WIDTH  datapath width of operands and immediate (default 32)
//   CNT_W  width of the bubble counter (default 16)
//
// Ports:
//   iclk, irst             clock, synchronous active-high reset
//   iStall, iFlush         hazard-unit hold / bubble request (flush wins)
//   iValid                 ID holds a real instruction
//   iRegWrite..iALUSrc     decoded control bits, iALUOp ALU operation class
//   iReadData1/2, iSignImm operands and sign-extended immediate
//   iRs, iRt, iRd          register specifiers
//   iWBRegWrite/iWBReg/iWBData  write-back port (bypass build only)
//   o*                     registered copies of the matching inputs
//   ofunct                 oSignImm[5:0], feeds the ALU control unit
//   oBubbles               saturating count of bubbles since reset
//
// Optional feature: define ID_EX_WB_BYPASS_EN to let a same-cycle register
// file write (WB port) override the rs/rt operands captured on a load.

module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iStall,
  input  logic             iFlush,
  input  logic             iValid,
  input  logic             iRegWrite,
  input  logic             iMemtoReg,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  input  logic             iRegDst,
  input  logic             iALUSrc,
  input  logic [1:0]       iALUOp,
  input  logic [WIDTH-1:0] iReadData1,
  input  logic [WIDTH-1:0] iReadData2,
  input  logic [WIDTH-1:0] iSignImm,
  input  logic [4:0]       iRs,
  input  logic [4:0]       iRt,
  input  logic [4:0]       iRd,
  input  logic             iWBRegWrite,
  input  logic [4:0]       iWBReg,
  input  logic [WIDTH-1:0] iWBData,
  output logic             oValid,
  output logic             oRegWrite,
  output logic             oMemtoReg,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oRegDst,
  output logic             oALUSrc,
  output logic [1:0]       oALUOp,
  output logic [WIDTH-1:0] oReadData1,
  output logic [WIDTH-1:0] oReadData2,
  output logic [WIDTH-1:0] oSignImm,
  output logic [4:0]       oRs,
  output logic [4:0]       oRt,
  output logic [4:0]       oRd,
  output logic [5:0]       ofunct,
  output logic [CNT_W-1:0] oBubbles
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             reg_dst;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
  } stage_t;

  stage_t           stage_d, stage_q;
  logic [CNT_W-1:0] bubbles_d, bubbles_q;
  logic             bubble;
  logic [WIDTH-1:0] op1, op2;

  // Operand selection: the register file is written at the end of the cycle
  // it is read, so an optional bypass forwards the WB data into the capture.
`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    op1 = iReadData1;
    op2 = iReadData2;
    if (iWBRegWrite && (iWBReg != 5'd0) && (iWBReg == iRs)) op1 = iWBData;
    if (iWBRegWrite && (iWBReg != 5'd0) && (iWBReg == iRt)) op2 = iWBData;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{iWBRegWrite, iWBReg, iWBData};
  assign op1 = iReadData1;
  assign op2 = iReadData2;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    stage_d   = stage_q;
    bubbles_d = bubbles_q;
    bubble    = 1'b0;

    if (iFlush) begin
      // Bubble: control cleared, data/specifiers zeroed for a tidy state.
      stage_d = '0;
      bubble  = 1'b1;
    end else if (!iStall) begin
      stage_d.valid      = iValid;
      stage_d.reg_write  = iRegWrite;
      stage_d.mem_to_reg = iMemtoReg;
      stage_d.mem_read   = iMemRead;
      stage_d.mem_write  = iMemWrite;
      stage_d.reg_dst    = iRegDst;
      stage_d.alu_src    = iALUSrc;
      stage_d.alu_op     = iALUOp;
      stage_d.rd1        = op1;
      stage_d.rd2        = op2;
      stage_d.imm        = iSignImm;
      stage_d.rs         = iRs;
      stage_d.rt         = iRt;
      stage_d.rd         = iRd;
      // An invalid slot from ID is itself a bubble: never let stale control
      // bits reach EX/MEM/WB.
      if (!iValid) begin
        stage_d.reg_write  = 1'b0;
        stage_d.mem_to_reg = 1'b0;
        stage_d.mem_read   = 1'b0;
        stage_d.mem_write  = 1'b0;
        stage_d.reg_dst    = 1'b0;
        stage_d.alu_src    = 1'b0;
        stage_d.alu_op     = 2'b00;
        bubble             = 1'b1;
      end
    end

    // Saturate at all-ones rather than wrapping.
    if (bubble && (bubbles_q != {CNT_W{1'b1}})) bubbles_d = bubbles_q + CNT_W'(1);
  end

  always_ff @(posedge iclk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (irst) begin
      stage_q   <= '0;
      bubbles_q <= '0;
    end else begin
      stage_q   <= stage_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign oValid     = stage_q.valid;
  assign oRegWrite  = stage_q.reg_write;
  assign oMemtoReg  = stage_q.mem_to_reg;
  assign oMemRead   = stage_q.mem_read;
  assign oMemWrite  = stage_q.mem_write;
  assign oRegDst    = stage_q.reg_dst;
  assign oALUSrc    = stage_q.alu_src;
  assign oALUOp     = stage_q.alu_op;
  assign oReadData1 = stage_q.rd1;
  assign oReadData2 = stage_q.rd2;
  assign oSignImm   = stage_q.imm;
  assign oRs        = stage_q.rs;
  assign oRt        = stage_q.rt;
  assign oRd        = stage_q.rd;
  assign ofunct     = stage_q.imm[5:0];
  assign oBubbles   = bubbles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// stall/flush/reset traffic, checked against a cycle model kept here. A second
// instance with a 4-bit counter exercises saturation.

module tb_id_ex_stage;

  localparam int WIDTH = 32;

  logic             iclk;
  logic             irst, iStall, iFlush, iValid;
  logic             iRegWrite, iMemtoReg, iMemRead, iMemWrite, iRegDst, iALUSrc;
  logic [1:0]       iALUOp;
  logic [WIDTH-1:0] iReadData1, iReadData2, iSignImm, iWBData;
  logic [4:0]       iRs, iRt, iRd, iWBReg;
  logic             iWBRegWrite;

  logic             oValid, oRegWrite, oMemtoReg, oMemRead, oMemWrite, oRegDst, oALUSrc;
  logic [1:0]       oALUOp;
  logic [WIDTH-1:0] oReadData1, oReadData2, oSignImm;
  logic [4:0]       oRs, oRt, oRd;
  logic [5:0]       ofunct;
  logic [15:0]      oBubbles;

  logic             s_valid, s_rw, s_m2r, s_mr, s_mw, s_rdst, s_asrc;
  logic [1:0]       s_aluop;
  logic [WIDTH-1:0] s_rd1, s_rd2, s_imm;
  logic [4:0]       s_rs, s_rt, s_rd;
  logic [5:0]       s_funct;
  logic [3:0]       s_bubbles;

  id_ex_stage #(.WIDTH(WIDTH), .CNT_W(16)) dut (
    .iclk(iclk), .irst(irst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iRegDst(iRegDst), .iALUSrc(iALUSrc), .iALUOp(iALUOp),
    .iReadData1(iReadData1), .iReadData2(iReadData2), .iSignImm(iSignImm),
    .iRs(iRs), .iRt(iRt), .iRd(iRd),
    .iWBRegWrite(iWBRegWrite), .iWBReg(iWBReg), .iWBData(iWBData),
    .oValid(oValid), .oRegWrite(oRegWrite), .oMemtoReg(oMemtoReg),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oRegDst(oRegDst),
    .oALUSrc(oALUSrc), .oALUOp(oALUOp), .oReadData1(oReadData1),
    .oReadData2(oReadData2), .oSignImm(oSignImm), .oRs(oRs), .oRt(oRt),
    .oRd(oRd), .ofunct(ofunct), .oBubbles(oBubbles)
  );

  id_ex_stage #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
    .iclk(iclk), .irst(irst), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
    .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iRegDst(iRegDst), .iALUSrc(iALUSrc), .iALUOp(iALUOp),
    .iReadData1(iReadData1), .iReadData2(iReadData2), .iSignImm(iSignImm),
    .iRs(iRs), .iRt(iRt), .iRd(iRd),
    .iWBRegWrite(iWBRegWrite), .iWBReg(iWBReg), .iWBData(iWBData),
    .oValid(s_valid), .oRegWrite(s_rw), .oMemtoReg(s_m2r),
    .oMemRead(s_mr), .oMemWrite(s_mw), .oRegDst(s_rdst),
    .oALUSrc(s_asrc), .oALUOp(s_aluop), .oReadData1(s_rd1),
    .oReadData2(s_rd2), .oSignImm(s_imm), .oRs(s_rs), .oRt(s_rt),
    .oRd(s_rd), .ofunct(s_funct), .oBubbles(s_bubbles)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_vec = 0;
  int n_err = 0;

  // Expected register contents (the model).
  logic             e_valid;
  logic [5:0]       e_ctrl;   // {RegWrite, MemtoReg, MemRead, MemWrite, RegDst, ALUSrc}
  logic [1:0]       e_aluop;
  logic [WIDTH-1:0] e_rd1, e_rd2, e_imm;
  logic [4:0]       e_rs, e_rt, e_rd;
  int               e_bub, e_bub_sat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] operand(input logic [4:0] spec, input logic [WIDTH-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    return (iWBRegWrite && iWBReg != 0 && iWBReg == spec) ? iWBData : rf;
`else
    return rf;
`endif
  endfunction

  // Advance the model by one edge from the current inputs, then clock and compare.
  task automatic step();
    logic bubble;
    bubble = 1'b0;
    if (irst) begin
      e_valid = 0; e_ctrl = 0; e_aluop = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_bub = 0; e_bub_sat = 0;
    end else if (iFlush) begin
      e_valid = 0; e_ctrl = 0; e_aluop = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0;
      bubble = 1'b1;
    end else if (!iStall) begin
      e_valid = iValid;
      e_ctrl  = iValid ? {iRegWrite, iMemtoReg, iMemRead, iMemWrite, iRegDst, iALUSrc} : 6'b0;
      e_aluop = iValid ? iALUOp : 2'b00;
      e_rd1   = operand(iRs, iReadData1);
      e_rd2   = operand(iRt, iReadData2);
      e_imm   = iSignImm;
      e_rs = iRs; e_rt = iRt; e_rd = iRd;
      bubble  = !iValid;
    end
    if (bubble) begin
      e_bub     = (e_bub < 65535) ? e_bub + 1 : 65535;
      e_bub_sat = (e_bub_sat < 15) ? e_bub_sat + 1 : 15;
    end
    @(posedge iclk);
    #1;
    check("valid", oValid, e_valid);
    check("ctrl", {oRegWrite, oMemtoReg, oMemRead, oMemWrite, oRegDst, oALUSrc}, e_ctrl);
    check("aluop", oALUOp, e_aluop);
    check("rd1", oReadData1, e_rd1);
    check("rd2", oReadData2, e_rd2);
    check("imm", oSignImm, e_imm);
    check("funct", ofunct, e_imm[5:0]);
    check("specs", {oRs, oRt, oRd}, {e_rs, e_rt, e_rd});
    check("bubbles", oBubbles, e_bub);
    check("sat_bubbles", s_bubbles, e_bub_sat);
    check("sat_path", {s_valid, s_rw, s_m2r, s_mr, s_mw, s_rdst, s_asrc, s_aluop,
                       s_rd1, s_funct}, {e_valid, e_ctrl, e_aluop, e_rd1, e_imm[5:0]});
  endtask

  task automatic clear_inputs();
    irst = 0; iStall = 0; iFlush = 0; iValid = 0;
    iRegWrite = 0; iMemtoReg = 0; iMemRead = 0; iMemWrite = 0; iRegDst = 0; iALUSrc = 0;
    iALUOp = 0; iReadData1 = 0; iReadData2 = 0; iSignImm = 0;
    iRs = 0; iRt = 0; iRd = 0; iWBRegWrite = 0; iWBReg = 0; iWBData = 0;
  endtask

  task automatic randomize_fields();
    iValid = $urandom_range(0, 3) != 0;
    {iRegWrite, iMemtoReg, iMemRead, iMemWrite, iRegDst, iALUSrc} = 6'($urandom);
    iALUOp = 2'($urandom);
    iReadData1 = $urandom; iReadData2 = $urandom; iSignImm = $urandom;
    iRs = 5'($urandom_range(0, 7)); iRt = 5'($urandom_range(0, 7)); iRd = 5'($urandom);
    iWBRegWrite = $urandom_range(0, 1) != 0;
    iWBReg = 5'($urandom_range(0, 7));
    iWBData = $urandom;
  endtask

  initial begin
    e_valid = 0; e_ctrl = 0; e_aluop = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0;
    e_rs = 0; e_rt = 0; e_rd = 0; e_bub = 0; e_bub_sat = 0;
    clear_inputs();

    // Reset for two cycles with busy inputs: everything must read zero.
    randomize_fields();
    iValid = 1; iFlush = 1;
    irst = 1;
    step();
    step();
    check("reset_bubbles", oBubbles, 16'd0);

    // Reset then load.
    clear_inputs();
    iValid = 1; iALUOp = 2'b10; iSignImm = 32'h0000_0020; iRegWrite = 1;
    step();
    check("load_funct", ofunct, 6'b100000);
    check("load_aluop", oALUOp, 2'b10);

    // Stall holds all registers for three cycles, then loading resumes.
    iReadData1 = 32'hDEAD_BEEF;
    step();
    iStall = 1; iReadData1 = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", oReadData1, 32'hDEAD_BEEF);
    end
    iStall = 0;
    step();
    check("stall_release", oReadData1, 32'h1234_5678);

    // Flush together with stall: flush wins and inserts a bubble.
    iFlush = 1; iStall = 1; iMemWrite = 1;
    step();
    check("flush_stall_bub", oBubbles, 16'd1);
    iFlush = 0; iStall = 0;

    // Invalid slot from ID: control forced off, counted as a bubble.
    iValid = 0; iRegWrite = 1; iALUOp = 2'b01;
    step();
    check("invalid_bub", oBubbles, 16'd2);

    // WB bypass on rs, then with register 0 as the write target.
    clear_inputs();
    iValid = 1; iRs = 5'd8; iWBReg = 5'd8; iWBRegWrite = 1; iWBData = 32'hCAFE_0001;
    step();
    iWBReg = 5'd0;
    step();
    check("bypass_r0", oReadData1, 32'h0);

    // Saturation of the 4-bit counter instance: 20 bubbles, then a few more.
    iFlush = 1;
    for (int i = 0; i < 22; i++) step();
    check("sat_value", s_bubbles, 4'hF);
    iFlush = 0;

    // Random traffic including reset mid-stall/mid-flush.
    for (int i = 0; i < 400; i++) begin
      randomize_fields();
      iStall = $urandom_range(0, 3) == 0;
      iFlush = $urandom_range(0, 7) == 0;
      irst   = $urandom_range(0, 39) == 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

The ID/EX pipeline register of the MIPS datapath. It captures decoded control bits, register-file operands, the sign-extended immediate and register specifiers at the end of ID, and presents them to EX for one cycle. Its `ofunct` and `oALUOp` outputs drive the ALU control unit directly. It supports hazard-unit stall (hold) and flush (bubble insertion), and keeps a saturating bubble counter for performance debug.

## Interface
- `WIDTH`, 32, datapath width of operands and immediate.
- `CNT_W`, 16, width of the bubble counter.
- `iclk` input 1: clock; all state updates on the rising edge.
- `irst` input 1: synchronous, active-high reset.
- `iStall` input 1: hold all registers, including valid.
- `iFlush` input 1: load a bubble next edge.
- `iValid` input 1: ID holds a real instruction.
- `iRegWrite`, `iMemtoReg`, `iMemRead`, `iMemWrite`, `iRegDst`, `iALUSrc` input 1 each: decoded control.
- `iALUOp` input 2: ALU operation class.
- `iReadData1`, `iReadData2` input WIDTH: register-file rs/rt read data.
- `iSignImm` input WIDTH: sign-extended immediate.
- `iRs`, `iRt`, `iRd` input 5: register specifiers.
- `iWBRegWrite` input 1, `iWBReg` input 5, `iWBData` input WIDTH: write-back port (used only with the bypass feature).
- Outputs: `oValid`, `oRegWrite`, `oMemtoReg`, `oMemRead`, `oMemWrite`, `oRegDst`, `oALUSrc` (1 each), `oALUOp` (2), `oReadData1`, `oReadData2`, `oSignImm` (WIDTH), `oRs`, `oRt`, `oRd` (5). Each is the registered copy of the matching input.
- `ofunct` output 6: equals `oSignImm[5:0]`; feeds the ALU control unit.
- `oBubbles` output CNT_W: count of bubbles inserted since reset, saturating.

## Operation
- Update priority each edge: `irst` > `iFlush` > `iStall` > load.
- Reset: all outputs are 0, including `oValid`, all control bits, `oALUOp` = 2'b00, data, specifiers and `oBubbles`.
- Flush:
  - `oValid`, `oRegWrite`, `oMemtoReg`, `oMemRead`, `oMemWrite`, `oRegDst`, `oALUSrc` become 0; `oALUOp` becomes 2'b00.
  - Data and specifier outputs are don't-care; the implementation zeroes them.
  - `oBubbles` increments.
- Stall without flush: every register, including `oBubbles`, holds its value.
- Load (neither flush nor stall):
  - All fields capture their inputs; `oValid` <= `iValid`.
  - If `iValid`=0, control bits are forced to 0 and `oALUOp` to 00 regardless of their inputs, and `oBubbles` increments.
- Simultaneous flush and stall: flush wins; a bubble is inserted.
- Bubble counter: `oBubbles` increments by 1 per inserted bubble and saturates at all-ones with no wrap.
- No combinational path from any input to any output.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N and stay stable until edge N+1.
- Stall held for k cycles: outputs are frozen for k cycles. Loading resumes on the first edge with `iStall`=0.
- Reset asserted mid-stall or mid-flush: the state is zero after that edge, and the counter restarts at 0.
- `ofunct` changes only on edges, together with `oSignImm`.

## Configuration
- `ID_EX_WB_BYPASS_EN` defined:
  - On a load, if `iWBRegWrite`=1, `iWBReg`!=0 and `iWBReg`==`iRs`, then `oReadData1` captures `iWBData` instead of `iReadData1`.
  - The same rule applies independently for `iRt` and `oReadData2`.
  - This covers a register-file write and read in the same cycle.
- Undefined: the WB ports are ignored and operands always come from `iReadData1`/`iReadData2`.

## Test plan
- Reset then load: assert `irst` for 2 cycles, then load `iValid`=1, `iALUOp`=2'b10, `iSignImm`=32'h0000_0020, `iRegWrite`=1 -> outputs are all 0 during reset. One edge after the load: `oALUOp`=2'b10, `ofunct`=6'b100000, `oRegWrite`=1, `oValid`=1.
- Stall: load `iReadData1`=32'hDEAD_BEEF, then hold `iStall`=1 for 3 cycles while driving `iReadData1`=32'h1234_5678 -> `oReadData1` stays DEAD_BEEF for 3 cycles. After release it becomes 1234_5678.
- Flush with stall: `iFlush`=1 and `iStall`=1 with `iMemWrite`=1 -> next edge `oValid`=0, `oMemWrite`=0, `oALUOp`=00, `oBubbles`=1.
- Invalid load: `iValid`=0, `iRegWrite`=1, `iALUOp`=2'b01 -> `oRegWrite`=0, `oALUOp`=00, `oBubbles` increments.
- Saturation: with `CNT_W`=4, insert 20 bubbles -> `oBubbles`=4'hF and it stays there.
- Bypass (with `ID_EX_WB_BYPASS_EN`): `iRs`=5'd8, `iWBReg`=5'd8, `iWBRegWrite`=1, `iWBData`=32'hCAFE_0001, `iReadData1`=0 -> `oReadData1`=CAFE_0001. With `iWBReg`=0 -> `oReadData1`=0. Without the macro -> `oReadData1`=0 in both cases.
